// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the shared-memory-port arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W      = 32;
  localparam int unsigned DEF_DATA_W      = 32;
  localparam int unsigned DEF_MAX_STREAK  = 2;
  localparam int unsigned DEF_TIMEOUT_CYC = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  // Data has priority unless fetch is waiting and the data streak is exhausted.
  function automatic logic dm_wins(input logic if_pend, input logic dm_pend,
                                   input logic at_limit);
    return dm_pend & ~(if_pend & at_limit);
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// BUSY-cycle timeout counter; only compiled when MEM_ARB_TIMEOUT_EN is defined.
`ifdef MEM_ARB_TIMEOUT_EN
module mem_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;

  // Fires during the TIMEOUT_CYC-th stalled BUSY cycle.
  assign expired = count_en && (cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (count_en && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter and sequencer for the single shared memory port.
// Define MEM_ARB_TIMEOUT_EN to enable the BUSY watchdog and the err abort path.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned MAX_STREAK  = DEF_MAX_STREAK,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_done,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_done,
  output logic                mem_valid,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall,
  output logic                err
);

  state_t     state, state_n;
  owner_t     owner;
  logic [1:0] streak;
  logic       if_pend, dm_pend, arb_en, at_limit;
  logic       grant_dm, grant_if, finish;
  logic       timeout, abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    if_pend = if_req;
    dm_pend = dm_req;
    // The requester being completed still shows its stale req during RESP.
    if (state == RESP) begin
      if (owner == OWN_IF) if_pend = 1'b0;
      else                 dm_pend = 1'b0;
    end
    arb_en   = (state == IDLE) || (state == RESP);
    at_limit = (streak == 2'(MAX_STREAK));
    grant_dm = arb_en & dm_wins(if_pend, dm_pend, at_limit);
    grant_if = arb_en & if_pend & ~grant_dm;
    finish   = (state == BUSY) & (mem_ready | timeout);
    case (state)
      IDLE:    if (grant_dm || grant_if) state_n = BUSY;
      BUSY:    if (finish) state_n = RESP;
      RESP:    state_n = (grant_dm || grant_if) ? BUSY : IDLE;
      default: state_n = IDLE;
    endcase
  end

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (grant_dm | grant_if),
    .count_en((state == BUSY) && !mem_ready),
    .expired (timeout)
  );
`else
  // TIMEOUT_CYC only matters with the watchdog; without it BUSY waits forever.
  assign timeout = (TIMEOUT_CYC == 0) & 1'b0;
`endif

  assign abort = timeout & ~mem_ready;
  assign stall = (if_req & ~if_done) | (dm_req & ~dm_done);

  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= OWN_IF;
      streak    <= '0;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      err       <= 1'b0;
    end else begin
      mem_valid <= (state_n == BUSY);
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
      err       <= 1'b0;
      if (grant_dm) begin
        owner     <= OWN_DM;
        mem_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        mem_be    <= dm_be;
        if (if_req && streak != 2'd3) streak <= streak + 2'd1;
      end else if (grant_if) begin
        owner     <= OWN_IF;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        mem_be    <= '1;
        streak    <= '0;
      end
      if (finish) begin
        err <= abort;
        if (owner == OWN_IF) begin
          if_done  <= 1'b1;
          if_rdata <= abort ? '0 : mem_rdata;
        end else begin
          dm_done <= 1'b1;
          if (!mem_we) dm_rdata <= abort ? '0 : mem_rdata;
        end
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter and sequencer for the single shared memory port of the CPU. It serves two requesters: instruction fetch, and the data path (loads and stores, raised when the control unit asserts `mem_read`/`mem_write`). It drives one request/ready memory interface, returns read data and a one-cycle `done` to the winning requester, and raises `stall` so the pipeline holds while any access is outstanding.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `MAX_STREAK`, 2: maximum consecutive data grants while fetch is waiting.
- `TIMEOUT_CYC`, 255: cycles in BUSY before abort. Used only with the macro.

Ports (one synchronous clock `clk`; synchronous, active-high reset `rst`):
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `if_req`  in  1  fetch request, held until `if_done`
- `if_addr`  in  ADDR_W  fetch address
- `if_rdata`  out  DATA_W  fetched instruction, valid while `if_done`=1
- `if_done`  out  1  one-cycle fetch completion
- `dm_req`  in  1  data request (`mem_read|mem_write`), held until `dm_done`
- `dm_we`  in  1  1 = store, 0 = load
- `dm_addr`  in  ADDR_W  data address
- `dm_wdata`  in  DATA_W  store data
- `dm_be`  in  DATA_W/8  byte enables
- `dm_rdata`  out  DATA_W  load data, valid while `dm_done`=1
- `dm_done`  out  1  one-cycle data completion
- `mem_valid`  out  1  memory request
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`  out  1/ADDR_W/DATA_W/DATA_W/8  request payload
- `mem_ready`  in  1  memory accepts and completes the request
- `mem_rdata`  in  DATA_W  read data, valid when `mem_valid & mem_ready`
- `stall`  out  1  pipeline hold
- `err`  out  1  timeout abort, pulses together with `done`

## Operation
- FSM states and transitions:
  - IDLE: on any request, go to BUSY.
  - BUSY: wait for `mem_valid & mem_ready`, then go to RESP.
  - RESP: pulse `done`; go to BUSY if the *other* requester is pending, otherwise go to IDLE.
- Arbitration:
  - Data wins over fetch.
  - 2-bit `streak` increments on each data grant while `if_req`=1 and clears on each fetch grant.
  - When `streak == MAX_STREAK` and `if_req`=1, fetch wins.
  - In RESP, the requester being completed is masked from arbitration.
- Payload handling:
  - Payload is registered at grant and held constant through BUSY.
  - `mem_valid`=1 only in BUSY.
- Completion:
  - `mem_rdata` is captured on `mem_valid & mem_ready` into the winner's `rdata`.
  - For stores, `dm_rdata` is not updated.
  - `if_rdata`/`dm_rdata` hold their value between accesses.
- Requester rule: drop or replace `req` on the edge that ends the `done` cycle.
- `stall = (if_req & ~if_done) | (dm_req & ~dm_done)`, combinational.
- Reset values: state=IDLE, `streak`=0, and every registered output (`mem_*`, `*_done`, `*_rdata`, `err`) = 0.
- Reset mid-access: `mem_valid` drops on the next edge and the transaction is abandoned without `done`. The memory must tolerate this.

## Timing
- Minimum latency: request seen in IDLE at cycle N → `mem_valid` at N+1 → with `mem_ready` at N+1, `done` at N+2 → IDLE at N+3.
- Each cycle `mem_ready`=0 in BUSY adds one cycle.
- Back-to-back alternating requesters: one access every 2 cycles (RESP→BUSY).
- Simultaneous `if_req` and `dm_req` in IDLE: data wins unless the streak limit is reached.
- `mem_ready` outside BUSY is ignored.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - The watchdog counts BUSY cycles with `mem_ready`=0.
  - At `TIMEOUT_CYC` it drops `mem_valid`, enters RESP, and pulses `done` and `err` together.
  - The aborted access returns `rdata` = 0.
  - The counter clears on entry to BUSY.
- Not defined: BUSY waits indefinitely and `err` is tied to 0.

## Structure
- Shared package `mem_arb_pkg` holds:
  - the state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2);
  - the owner encoding (OWN_IF=1'b0, OWN_DM=1'b1);
  - the default widths.
- Sub-module `mem_arb_watchdog` holds the timeout counter. It is instantiated only under `MEM_ARB_TIMEOUT_EN`.

## Test plan
- Single load: `dm_req`=1, `dm_we`=0, addr 0x100; memory answers 0xCAFEF00D with `mem_ready` at the first BUSY cycle → `dm_done` at N+2 with `dm_rdata`=0xCAFEF00D, `stall` low at N+3.
- Contention: `if_req` and `dm_req` held continuously, `mem_ready` always 1, MAX_STREAK=2 → grant order DM, IF, DM, IF. Each fetch is reached within 2 data grants and grants are spaced 2 cycles apart.
- Wait states: store 0x12345678, be=4'b0011, `mem_ready` low for 5 cycles → `mem_valid` and payload stable for 6 cycles, `dm_done` 1 cycle later, `dm_rdata` unchanged.
- Reset in BUSY: assert `rst` mid-wait → next edge `mem_valid`=0, no `done`, state IDLE, all outputs 0.
- Timeout (`MEM_ARB_TIMEOUT_EN`, TIMEOUT_CYC=8): `mem_ready` held low → after 8 BUSY cycles, `if_done`=1, `err`=1, `if_rdata`=0. Without the macro, the access still waits after 100 cycles.
